// File: rtl/image_pkg.sv
// Shared types and constants for the image pipeline (blur -> grayscale).
package image_pkg;

  // Frame geometry defaults, also used by the blur block.
  localparam int unsigned DefaultWidth  = 20;
  localparam int unsigned DefaultHeight = 12;

  // BT.601-style luma weights scaled by 256; they sum to 256.
  localparam int unsigned LumaCoefR  = 77;
  localparam int unsigned LumaCoefG  = 150;
  localparam int unsigned LumaCoefB  = 29;
  localparam int unsigned LumaRound  = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Rounded 8-bit luma; the 16-bit sum peaks at 65408, so it never wraps.
  function automatic logic [7:0] luma_of(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'(LumaCoefR) * 16'(r) + 16'(LumaCoefG) * 16'(g) + 16'(LumaCoefB) * 16'(b)
        + 16'(LumaRound);
    return acc[15:8];
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding {last, data} luma entries.
module pixel_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 9,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [DataW-1:0] push_data_i,
  input  logic             pop_i,
  output logic [DataW-1:0] pop_data_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CntW'(Depth));
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A push at full is allowed only when a pop frees the slot on the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Storage, pointers and occupancy; Depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CntW'(1);
      else if (!push_ok && pop_ok) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/image_grayscale.sv
// Byte-serial RGB to 8-bit luma converter with frame tracking and output FIFO.
module image_grayscale
  import image_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned HEIGHT     = DefaultHeight,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  input  logic       out_ready_i,
  output logic       out_last_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned Total    = WIDTH * HEIGHT;
  localparam int unsigned CntW     = $clog2(Total + 1);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);

  state_e          state_q;
  logic [1:0]      color_q;
  logic [7:0]      r_q, g_q;
  logic [CntW-1:0] pix_q;

  logic [FifoCntW-1:0] fifo_count;
  logic                fifo_empty, fifo_full;
  logic [8:0]          fifo_rdata;
  logic                in_fire, push, pop, last_pix;
  logic                unused_full;

  assign unused_full = fifo_full;

  // Ready is based on occupancy alone so an accepted B beat always has a free slot.
  assign in_ready_o  = (state_q == StRun) && (fifo_count < FifoCntW'(FIFO_DEPTH));
  assign in_fire     = in_valid_i && in_ready_o;
  assign push        = in_fire && (color_q == 2'd2);
  assign last_pix    = (pix_q == CntW'(Total - 1));

  assign out_valid_o = !fifo_empty;
  assign out_data_o  = fifo_rdata[7:0];
  assign out_last_o  = out_valid_o && fifo_rdata[8];
  assign pop         = out_valid_o && out_ready_i;

  assign busy_o      = (state_q == StRun) || (state_q == StDrain);
  assign done_o      = (state_q == StDone);

  // Frame FSM with colour phase, stored R/G and pixel counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      color_q <= 2'd0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      pix_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q <= StRun;
            color_q <= 2'd0;
            pix_q   <= '0;
          end
        end
        StRun: begin
          if (in_fire) begin
            unique case (color_q)
              2'd0: begin
                r_q     <= in_data_i;
                color_q <= 2'd1;
              end
              2'd1: begin
                g_q     <= in_data_i;
                color_q <= 2'd2;
              end
              default: begin
                color_q <= 2'd0;
                pix_q   <= pix_q + CntW'(1);
                if (last_pix) state_q <= StDrain;
              end
            endcase
          end
        end
        StDrain: begin
          if (out_last_o && out_ready_i) state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pixel_fifo #(
    .Depth (FIFO_DEPTH),
    .DataW (9)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i ({last_pix, luma_of(r_q, g_q, in_data_i)}),
    .pop_i       (pop),
    .pop_data_o  (fifo_rdata),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

endmodule

// File: tb/tb_image_grayscale.sv
// Randomized bench for image_grayscale against an arithmetic luma model.
module tb_image_grayscale;

  localparam int NPix = 240;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [7:0] in_data, out_data;
  logic       s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
  logic       s_busy, s_done;
  logic [7:0] s_in_data, s_out_data;

  image_grayscale #(.WIDTH(20), .HEIGHT(12), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_ready_i(out_ready), .out_last_o(out_last), .busy_o(busy), .done_o(done)
  );

  image_grayscale #(.WIDTH(1), .HEIGHT(1), .FIFO_DEPTH(4)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .in_valid_i(s_in_valid),
    .in_data_i(s_in_data), .in_ready_o(s_in_ready), .out_valid_o(s_out_valid),
    .out_data_o(s_out_data), .out_ready_i(s_out_ready), .out_last_o(s_out_last),
    .busy_o(s_busy), .done_o(s_done)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] pr [NPix];
  logic [7:0] pg [NPix];
  logic [7:0] pb [NPix];
  logic [7:0] exp_b [NPix];
  logic [8:0] prev_got [NPix];
  logic [8:0] got_q [$];
  int         beats = 0;

  // Record output transfers and accepted input beats (values are stable at negedge).
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back({out_last, out_data});
    if (in_valid === 1'b1 && in_ready === 1'b1) beats++;
  end

  function automatic int ref_luma(int r, int g, int b);
    return (77 * r + 150 * g + 29 * b + 128) / 256;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NPix; i++) begin
      pr[i] = 8'($urandom_range(0, 255));
      pg[i] = 8'($urandom_range(0, 255));
      pb[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic compute_expected();
    for (int i = 0; i < NPix; i++) exp_b[i] = 8'(ref_luma(int'(pr[i]), int'(pg[i]), int'(pb[i])));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drive nbytes of the pixel arrays; gap!=0 inserts an idle cycle before every byte.
  task automatic send_stream(input int gap, input int nbytes, input int start_at, output bit ok);
    int p, c, n;
    ok = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      p = k / 3;
      c = k % 3;
      if (gap != 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = (c == 0) ? pr[p] : (c == 1) ? pg[p] : pb[p];
      if (k == start_at) start = 1'b1;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 5000) begin
        n++;
        @(negedge clk);
      end
      if (in_ready !== 1'b1) begin
        ok = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!(done === 1'b1 && got_q.size() >= NPix) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; in_valid = 0; in_data = 0; out_ready = 1;
    s_start = 0; s_in_valid = 0; s_in_data = 0; s_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'd0) begin bad++; $display("FAIL rst_out_data got=%0d want=0", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b want=0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL idle_after_rst busy=%b in_ready=%b want 0,0", busy, in_ready);
    end
  endtask

  task automatic test_single_pixel();
    int n;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'd80;
      n = 0;
      @(negedge clk);
      while (s_in_ready !== 1'b1 && n < 100) begin n++; @(negedge clk); end
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    total++; if (s_out_valid !== 1'b1 || s_out_data !== 8'd80 || s_out_last !== 1'b1) begin
      bad++; $display("FAIL single_out got v=%b d=%0d l=%b want v=1 d=80 l=1",
                      s_out_valid, s_out_data, s_out_last);
    end
    @(posedge clk); #1;
    total++; if (s_done !== 1'b1 || s_out_valid !== 1'b0) begin
      bad++; $display("FAIL single_done got done=%b v=%b want done=1 v=0", s_done, s_out_valid);
    end
  endtask

  task automatic test_colors();
    bit ok;
    logic [7:0] want [5];
    want[0] = 8'd77; want[1] = 8'd149; want[2] = 8'd29; want[3] = 8'd255; want[4] = 8'd0;
    fill_random();
    pr[0] = 255; pg[0] = 0;   pb[0] = 0;
    pr[1] = 0;   pg[1] = 255; pb[1] = 0;
    pr[2] = 0;   pg[2] = 0;   pb[2] = 255;
    pr[3] = 255; pg[3] = 255; pb[3] = 255;
    pr[4] = 0;   pg[4] = 0;   pb[4] = 0;
    compute_expected();
    got_q.delete();
    out_ready = 1'b1;
    pulse_start();
    send_stream(0, NPix * 3, -1, ok);
    total++; if (!ok) begin bad++; $display("FAIL colors_send timeout got=0 want=1"); end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL colors_done got=%b want=1", done); end
    total++; if (got_q.size() != NPix) begin
      bad++; $display("FAIL colors_count got=%0d want=%0d", got_q.size(), NPix);
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      total++; if (got_q[i][7:0] !== want[i]) begin
        bad++; $display("FAIL color_px%0d got=%0d want=%0d", i, got_q[i][7:0], want[i]);
      end
    end
    for (int i = 0; i < NPix && i < got_q.size(); i++) begin
      prev_got[i] = got_q[i];
      total++; if (got_q[i] !== {1'(i == NPix - 1), exp_b[i]}) begin
        bad++; $display("FAIL colors_px%0d got=%h want=%h", i, got_q[i], {1'(i == NPix - 1), exp_b[i]});
      end
    end
  endtask

  task automatic test_gaps();
    bit ok;
    got_q.delete();
    pulse_start();
    send_stream(1, NPix * 3, -1, ok);
    total++; if (!ok) begin bad++; $display("FAIL gaps_send timeout got=0 want=1"); end
    wait_done(ok);
    total++; if (!ok || got_q.size() != NPix) begin
      bad++; $display("FAIL gaps_done got done=%b n=%0d want 1,%0d", done, got_q.size(), NPix);
    end
    for (int i = 0; i < NPix && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== prev_got[i] || got_q[i] !== {1'(i == NPix - 1), exp_b[i]}) begin
        bad++; $display("FAIL gaps_px%0d got=%h want=%h", i, got_q[i], {1'(i == NPix - 1), exp_b[i]});
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    fill_random();
    compute_expected();
    got_q.delete();
    out_ready = 1'b0;
    pulse_start();
    beats = 0;
    fork
      send_stream(0, NPix * 3, -1, ok);
      begin
        repeat (80) @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        total++; if (beats != 12) begin bad++; $display("FAIL bp_beats got=%0d want=12", beats); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL bp_early_out got=%0d want=0", got_q.size()); end
        total++; if (out_valid !== 1'b1 || out_data !== exp_b[0] || out_last !== 1'b0) begin
          bad++; $display("FAIL bp_head got v=%b d=%0d l=%b want v=1 d=%0d l=0",
                          out_valid, out_data, out_last, exp_b[0]);
        end
        repeat (5) @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== exp_b[0]) begin
          bad++; $display("FAIL bp_hold got v=%b d=%0d want v=1 d=%0d", out_valid, out_data, exp_b[0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    total++; if (!ok) begin bad++; $display("FAIL bp_send timeout got=0 want=1"); end
    wait_done(ok2);
    total++; if (!ok2 || got_q.size() != NPix) begin
      bad++; $display("FAIL bp_done got done=%b n=%0d want 1,%0d", done, got_q.size(), NPix);
    end
    for (int i = 0; i < NPix && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== {1'(i == NPix - 1), exp_b[i]}) begin
        bad++; $display("FAIL bp_px%0d got=%h want=%h", i, got_q[i], {1'(i == NPix - 1), exp_b[i]});
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    fill_random();
    out_ready = 1'b1;
    pulse_start();
    send_stream(0, 36 * 3 + 2, -1, ok);
    rst_n = 1'b0;
    #2;
    total++; if (out_valid !== 0 || out_data !== 0 || out_last !== 0 || busy !== 0 || done !== 0 ||
                 in_ready !== 0) begin
      bad++; $display("FAIL midrst_outputs got v=%b d=%0d l=%b busy=%b done=%b rdy=%b want all 0",
                      out_valid, out_data, out_last, busy, done, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_idle got busy=%b done=%b v=%b want 0,0,0", busy, done, out_valid);
    end
    fill_random();
    compute_expected();
    got_q.delete();
    pulse_start();
    send_stream(0, NPix * 3, -1, ok);
    wait_done(ok);
    total++; if (!ok || got_q.size() != NPix) begin
      bad++; $display("FAIL midrst_frame got done=%b n=%0d want 1,%0d", done, got_q.size(), NPix);
    end
    for (int i = 0; i < NPix && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== {1'(i == NPix - 1), exp_b[i]}) begin
        bad++; $display("FAIL midrst_px%0d got=%h want=%h", i, got_q[i], {1'(i == NPix - 1), exp_b[i]});
      end
    end
  endtask

  task automatic test_restart();
    bit ok;
    fill_random();
    compute_expected();
    got_q.delete();
    pulse_start();
    // start asserted alongside pixel 100's R beat, while running
    send_stream(0, NPix * 3, 100 * 3, ok);
    wait_done(ok);
    total++; if (!ok || got_q.size() != NPix) begin
      bad++; $display("FAIL ign_frame got done=%b n=%0d want 1,%0d", done, got_q.size(), NPix);
    end
    for (int i = 0; i < NPix && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== {1'(i == NPix - 1), exp_b[i]}) begin
        bad++; $display("FAIL ign_px%0d got=%h want=%h", i, got_q[i], {1'(i == NPix - 1), exp_b[i]});
      end
    end
    fill_random();
    compute_expected();
    got_q.delete();
    pulse_start();
    total++; if (done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_state got done=%b busy=%b want 0,1", done, busy);
    end
    send_stream(0, NPix * 3, -1, ok);
    wait_done(ok);
    total++; if (!ok || got_q.size() != NPix) begin
      bad++; $display("FAIL restart_frame got done=%b n=%0d want 1,%0d", done, got_q.size(), NPix);
    end
    for (int i = 0; i < NPix && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== {1'(i == NPix - 1), exp_b[i]}) begin
        bad++; $display("FAIL restart_px%0d got=%h want=%h", i, got_q[i], {1'(i == NPix - 1), exp_b[i]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_colors();
    test_gaps();
    test_backpressure();
    test_reset_midframe();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
